// File: rtl/contador_updown_m_if.sv
// Control and data bundle for the up/down modulo counter.
// The master side drives the controls and load data; the slave side is the counter.
interface contador_updown_m_if #(
   parameter int N = 4
);
   logic         zera;
   logic         ld;
   logic         ent;
   logic         enp;
   logic         up;
   logic [N-1:0] D;
   logic [N-1:0] Q;
   logic         rco;
   logic         wrap;

   modport master (
      output zera, ld, ent, enp, up, D,
      input  Q, rco, wrap
   );

   modport slave (
      input  zera, ld, ent, enp, up, D,
      output Q, rco, wrap
   );
endinterface

// File: rtl/contador_updown_m.sv
// Parametrised up/down counter, modulo M, N bits wide.
// Keeps the 74163 control set: synchronous active-low load, and ent/enp
// count enables with a combinational ripple-carry output gated by ent.
// Adds async active-low clear, synchronous clear, direction and a
// registered one-cycle wrap pulse.
module contador_updown_m #(
   parameter int N = 4,
   parameter int M = 16
) (
   input logic                clock,
   input logic                clr,
   contador_updown_m_if.slave bus
);

   // Terminal count. M-1 always fits in N bits because M <= 2**N, so every
   // comparison below stays N bits wide and M == 2**N wraps naturally.
   localparam logic [N-1:0] LAST = N'(M - 1);

   logic [N-1:0] q_reg;
   logic         wrap_reg;
   logic         at_last;
   logic         at_zero;
   logic         past_last;
   logic         count_en;

   assign at_last   = (q_reg == LAST);
   assign at_zero   = (q_reg == '0);
   // Loaded values above M-1 are treated like the terminal count when counting up.
   assign past_last = (q_reg >= LAST);
   assign count_en  = bus.ent & bus.enp;

   // Counter state: async clear, then zera > load > count > hold on each edge.
   always_ff @(posedge clock or negedge clr) begin
      if (!clr) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
      end else if (bus.zera) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
      end else if (!bus.ld) begin
         q_reg    <= bus.D;
         wrap_reg <= 1'b0;
      end else if (count_en) begin
         if (bus.up) begin
            if (past_last) begin
               q_reg    <= '0;
               wrap_reg <= 1'b1;
            end else begin
               q_reg    <= q_reg + N'(1);
               wrap_reg <= 1'b0;
            end
         end else begin
            if (at_zero) begin
               q_reg    <= LAST;
               wrap_reg <= 1'b1;
            end else begin
               q_reg    <= q_reg - N'(1);
               wrap_reg <= 1'b0;
            end
         end
      end else begin
         wrap_reg <= 1'b0;
      end
   end

   // Ripple carry/borrow: only ent gates it, so cascaded stages chain through ent.
   always_comb begin
      bus.rco = bus.ent & ((bus.up & at_last) | (~bus.up & at_zero));
   end

   assign bus.Q    = q_reg;
   assign bus.wrap = wrap_reg;

endmodule

// File: tb/tb_contador_updown_m.sv
// Self-checking bench for contador_updown_m: directed scenarios on an
// N=4/M=10 and an N=3/M=8 instance, plus randomized traffic checked
// against a behavioural model of the counting rules.
module tb_contador_updown_m;

   localparam int NA = 4;
   localparam int MA = 10;
   localparam int NB = 3;
   localparam int MB = 8;

   logic clock = 1'b0;
   logic clr_a;
   logic clr_b;

   always #5 clock = ~clock;

   contador_updown_m_if #(.N(NA)) bus_a ();
   contador_updown_m_if #(.N(NB)) bus_b ();

   contador_updown_m #(.N(NA), .M(MA)) dut_a (
      .clock (clock),
      .clr   (clr_a),
      .bus   (bus_a.slave)
   );

   contador_updown_m #(.N(NB), .M(MB)) dut_b (
      .clock (clock),
      .clr   (clr_b),
      .bus   (bus_b.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   // Model state: counter value as a plain integer, and last-edge wrap flag
   int mqa, mqb;
   bit mwa, mwb;

   // One clock edge of the counting rules, in integer arithmetic
   function automatic void model_step(input int m, input bit zera, input bit ld,
                                      input bit ent, input bit enp, input bit up,
                                      input int d, inout int q, inout bit w);
      w = 1'b0;
      if (zera)            q = 0;
      else if (!ld)        q = d;
      else if (ent && enp) begin
         if (up) begin
            if (q + 1 >= m) begin q = 0; w = 1'b1; end
            else q = q + 1;
         end else begin
            if (q == 0) begin q = m - 1; w = 1'b1; end
            else q = q - 1;
         end
      end
   endfunction

   function automatic bit exp_rco(input int m, input int q, input bit ent, input bit up);
      return ent && ((up && q == m - 1) || (!up && q == 0));
   endfunction

   task automatic drive_a(input bit zera, input bit ld, input bit ent, input bit enp,
                          input bit up, input int d);
      bus_a.zera = zera; bus_a.ld = ld; bus_a.ent = ent;
      bus_a.enp  = enp;  bus_a.up = up; bus_a.D   = NA'(d);
   endtask

   task automatic drive_b(input bit zera, input bit ld, input bit ent, input bit enp,
                          input bit up, input int d);
      bus_b.zera = zera; bus_b.ld = ld; bus_b.ent = ent;
      bus_b.enp  = enp;  bus_b.up = up; bus_b.D   = NB'(d);
   endtask

   // Advance one edge; model follows the inputs that were stable across it
   task automatic tick_a();
      @(posedge clock);
      #1;
      model_step(MA, bus_a.zera, bus_a.ld, bus_a.ent, bus_a.enp, bus_a.up,
                 int'(bus_a.D), mqa, mwa);
   endtask

   task automatic tick_b();
      @(posedge clock);
      #1;
      model_step(MB, bus_b.zera, bus_b.ld, bus_b.ent, bus_b.enp, bus_b.up,
                 int'(bus_b.D), mqb, mwb);
      // instance A sees the same edge; its inputs are idle-held during B tests
      model_step(MA, bus_a.zera, bus_a.ld, bus_a.ent, bus_a.enp, bus_a.up,
                 int'(bus_a.D), mqa, mwa);
   endtask

   task automatic test_reset();
      clr_a = 1'b0;
      clr_b = 1'b0;
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      drive_b(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      repeat (3) @(posedge clock);
      #2;
      compared++;
      if (bus_a.Q !== 4'd0 || bus_a.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_a: Q=%0d wrap=%b, want Q=0 wrap=0", bus_a.Q, bus_a.wrap);
      end
      compared++;
      if (bus_b.Q !== 3'd0 || bus_b.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_b: Q=%0d wrap=%b, want Q=0 wrap=0", bus_b.Q, bus_b.wrap);
      end
      // rco is combinational and ignores clr: ent=1, up=0, Q=0 -> 1
      compared++;
      if (bus_a.rco !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_rco: rco=%b, want 1", bus_a.rco);
      end
      drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      drive_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      clr_a = 1'b1;
      clr_b = 1'b1;
      mqa = 0; mwa = 1'b0; mqb = 0; mwb = 1'b0;
      $display("reset: Q_a=%0d Q_b=%0d", bus_a.Q, bus_b.Q);
   endtask

   task automatic test_count_up();
      // get a nonzero value, then clear asynchronously mid-cycle
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
      tick_a();
      drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      #2;
      clr_a = 1'b0;
      #1;
      compared++;
      if (bus_a.Q !== 4'd0 || bus_a.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL async_clr: Q=%0d wrap=%b, want Q=0 wrap=0", bus_a.Q, bus_a.wrap);
      end
      clr_a = 1'b1;
      mqa = 0; mwa = 1'b0;
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      for (int i = 1; i <= 12; i++) begin
         tick_a();
         compared++;
         if (int'(bus_a.Q) !== i % MA || bus_a.wrap !== (i == 10) ||
             bus_a.rco !== (i % MA == 9)) begin
            mismatched++;
            $display("FAIL count_up[%0d]: Q=%0d wrap=%b rco=%b, want Q=%0d wrap=%b rco=%b",
                     i, bus_a.Q, bus_a.wrap, bus_a.rco, i % MA, (i == 10), (i % MA == 9));
         end
         $display("count_up edge %0d: Q=%0d wrap=%b rco=%b", i, bus_a.Q, bus_a.wrap, bus_a.rco);
      end
   endtask

   task automatic test_count_down();
      drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      tick_a();
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      #1;
      compared++;
      if (bus_a.Q !== 4'd0 || bus_a.rco !== 1'b1) begin
         mismatched++;
         $display("FAIL down_start: Q=%0d rco=%b, want Q=0 rco=1", bus_a.Q, bus_a.rco);
      end
      for (int i = 1; i <= 3; i++) begin
         tick_a();
         compared++;
         if (int'(bus_a.Q) !== MA - i || bus_a.wrap !== (i == 1) || bus_a.rco !== 1'b0) begin
            mismatched++;
            $display("FAIL count_down[%0d]: Q=%0d wrap=%b rco=%b, want Q=%0d wrap=%b rco=0",
                     i, bus_a.Q, bus_a.wrap, bus_a.rco, MA - i, (i == 1));
         end
         $display("count_down edge %0d: Q=%0d wrap=%b", i, bus_a.Q, bus_a.wrap);
      end
   endtask

   task automatic test_load_out_of_range();
      drive_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 13);
      tick_a();
      compared++;
      if (bus_a.Q !== 4'd13 || bus_a.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL load13: Q=%0d wrap=%b, want Q=13 wrap=0", bus_a.Q, bus_a.wrap);
      end
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      tick_a();
      compared++;
      if (bus_a.Q !== 4'd0 || bus_a.wrap !== 1'b1) begin
         mismatched++;
         $display("FAIL oob_up: Q=%0d wrap=%b, want Q=0 wrap=1", bus_a.Q, bus_a.wrap);
      end
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13);
      tick_a();
      drive_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 1; i <= 2; i++) begin
         tick_a();
         compared++;
         if (int'(bus_a.Q) !== 13 - i || bus_a.wrap !== 1'b0) begin
            mismatched++;
            $display("FAIL oob_down[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=0",
                     i, bus_a.Q, bus_a.wrap, 13 - i);
         end
      end
      $display("load_oob: final Q=%0d", bus_a.Q);
   endtask

   task automatic test_hold_rco();
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
      tick_a();
      drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
      for (int i = 1; i <= 3; i++) begin
         tick_a();
         compared++;
         if (bus_a.Q !== 4'd9 || bus_a.rco !== 1'b1 || bus_a.wrap !== 1'b0) begin
            mismatched++;
            $display("FAIL hold[%0d]: Q=%0d rco=%b wrap=%b, want Q=9 rco=1 wrap=0",
                     i, bus_a.Q, bus_a.rco, bus_a.wrap);
         end
      end
      bus_a.ent = 1'b0;
      #1;
      compared++;
      if (bus_a.rco !== 1'b0) begin
         mismatched++;
         $display("FAIL rco_ent0: rco=%b, want 0", bus_a.rco);
      end
      bus_a.ent = 1'b1;
      bus_a.up  = 1'b0;
      #1;
      compared++;
      if (bus_a.rco !== 1'b0 || bus_a.Q !== 4'd9) begin
         mismatched++;
         $display("FAIL rco_dir: rco=%b Q=%0d, want rco=0 Q=9", bus_a.rco, bus_a.Q);
      end
      $display("hold: Q=%0d rco=%b", bus_a.Q, bus_a.rco);
   endtask

   task automatic test_priority();
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
      tick_a();
      drive_a(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7);
      tick_a();
      compared++;
      if (bus_a.Q !== 4'd0) begin
         mismatched++;
         $display("FAIL zera_over_ld: Q=%0d, want 0", bus_a.Q);
      end
      drive_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7);
      tick_a();
      compared++;
      if (bus_a.Q !== 4'd7 || bus_a.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL ld_over_count: Q=%0d wrap=%b, want Q=7 wrap=0", bus_a.Q, bus_a.wrap);
      end
      // load at the terminal count while counting: load wins, no wrap pulse
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
      tick_a();
      drive_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
      tick_a();
      compared++;
      if (bus_a.Q !== 4'd2 || bus_a.wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL ld_at_last: Q=%0d wrap=%b, want Q=2 wrap=0", bus_a.Q, bus_a.wrap);
      end
      $display("priority: Q=%0d", bus_a.Q);
   endtask

   task automatic test_mod8();
      drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      drive_b(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      tick_b();
      drive_b(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
      begin
         int pulses = 0;
         int first_at = -1;
         int second_at = -1;
         for (int i = 1; i <= 16; i++) begin
            tick_b();
            if (bus_b.wrap === 1'b1) begin
               pulses++;
               if (first_at < 0) first_at = i;
               else second_at = i;
            end
            compared++;
            if (int'(bus_b.Q) !== i % MB) begin
               mismatched++;
               $display("FAIL mod8[%0d]: Q=%0d, want %0d", i, bus_b.Q, i % MB);
            end
         end
         compared++;
         if (pulses != 2 || second_at - first_at != MB) begin
            mismatched++;
            $display("FAIL mod8_wrap: pulses=%0d spacing=%0d, want pulses=2 spacing=%0d",
                     pulses, second_at - first_at, MB);
         end
         $display("mod8: pulses=%0d at edges %0d,%0d", pulses, first_at, second_at);
      end
      tick_b();
      #2;
      clr_b = 1'b0;
      #1;
      compared++;
      if (bus_b.Q !== 3'd0) begin
         mismatched++;
         $display("FAIL mod8_clr: Q=%0d, want 0", bus_b.Q);
      end
      clr_b = 1'b1;
      mqb = 0; mwb = 1'b0;
   endtask

   // Randomized traffic on one instance, each edge checked against the model
   task automatic test_random(input bit use_b, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         bit zera = ($urandom_range(15) == 0);
         bit ld   = ($urandom_range(7) != 0);
         bit ent  = ($urandom_range(5) != 0);
         bit enp  = ($urandom_range(5) != 0);
         bit up   = ($urandom_range(3) != 0) ? use_b ^ bit'(i / 40 % 2) : bit'($urandom_range(1));
         int d    = int'($urandom_range(use_b ? 7 : 15));
         int q_obs, q_exp;
         bit w_obs, w_exp, r_obs, r_exp;
         if (use_b) drive_b(zera, ld, ent, enp, up, d);
         else       drive_a(zera, ld, ent, enp, up, d);
         #1;
         if ($urandom_range(39) == 0) begin
            if (use_b) clr_b = 1'b0; else clr_a = 1'b0;
            #1;
            if (use_b) begin clr_b = 1'b1; mqb = 0; mwb = 1'b0; end
            else       begin clr_a = 1'b1; mqa = 0; mwa = 1'b0; end
         end
         r_obs = use_b ? bus_b.rco : bus_a.rco;
         r_exp = use_b ? exp_rco(MB, mqb, ent, up) : exp_rco(MA, mqa, ent, up);
         compared++;
         if (r_obs !== r_exp) begin
            mismatched++;
            $display("FAIL rand_rco[%0d]: rco=%b, want %b", i, r_obs, r_exp);
         end
         if (use_b) tick_b(); else tick_a();
         q_obs = use_b ? int'(bus_b.Q) : int'(bus_a.Q);
         w_obs = use_b ? bus_b.wrap : bus_a.wrap;
         q_exp = use_b ? mqb : mqa;
         w_exp = use_b ? mwb : mwa;
         compared++;
         if (q_obs !== q_exp || w_obs !== w_exp) begin
            mismatched++;
            $display("FAIL rand_%s[%0d]: Q=%0d wrap=%b, want Q=%0d wrap=%b",
                     use_b ? "b" : "a", i, q_obs, w_obs, q_exp, w_exp);
         end
         $display("rand_%s %0d: z=%b ld=%b ent=%b enp=%b up=%b D=%0d -> Q=%0d wrap=%b",
                  use_b ? "b" : "a", i, zera, ld, ent, enp, up, d, q_obs, w_obs);
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_load_out_of_range();
      test_hold_rco();
      test_priority();
      test_mod8();
      drive_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      test_random(1'b0, 300);
      drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
      test_random(1'b1, 300);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/contador_updown_m.md
Name: contador_updown_m

Overview:
Parametrised synchronous up/down counter, modulo M, N bits wide. It keeps the 74163-style control set: active-low synchronous load, and ent/enp count enables with ripple-carry output. It adds an asynchronous active-low reset, a synchronous clear, a count-direction input, an arbitrary modulus and a registered wrap pulse. It is intended as the general-purpose counter (address, timer, round counters) for the datapaths of upcoming experiments.

Parameters:
N, 4, counter width in bits (N >= 1)
M, 16, modulus; count sequence 0..M-1 (2 <= M <= 2**N)

Ports:
clock  input  1  system clock, all state updates on rising edge
clr  input  1  asynchronous reset, active-low; forces Q=0 and wrap=0 immediately
zera  input  1  synchronous clear, active-high
ld  input  1  synchronous parallel load, active-low
ent  input  1  count enable T (also gates rco)
enp  input  1  count enable P
up  input  1  direction: 1 = increment, 0 = decrement
D  input  N  parallel load data
Q  output  N  counter value (register)
rco  output  1  ripple-carry/borrow, combinational
wrap  output  1  registered one-cycle pulse: counter wrapped on the previous edge

Behaviour:
- Reset: clr=0 (asynchronous, independent of clock) sets Q=0 and wrap=0. Both hold while clr=0. The first rising edge after clr returns to 1 evaluates normally.
- Priority at each rising edge with clr=1: zera > ld > count > hold.
  - zera=1: Q<=0, wrap<=0.
  - else ld=0: Q<=D, wrap<=0. D is loaded verbatim, even if D >= M.
  - else ent=1 and enp=1: count (see below).
  - else: Q holds, wrap<=0.
- Count up (up=1):
  - Q < M-1: Q<=Q+1, wrap<=0.
  - Q >= M-1: Q<=0, wrap<=1. This covers the out-of-range loaded values.
- Count down (up=0):
  - Q == 0: Q<=M-1, wrap<=1.
  - Q > 0: Q<=Q-1, wrap<=0. This includes out-of-range values, which decrement one step per edge.
- When M == 2**N the wrap is the natural N-bit wrap. No arithmetic may overflow a wider intermediate in a way that changes the result.
- rco is combinational and not registered. rco = ent AND ((up=1 AND Q==M-1) OR (up=0 AND Q==0)).
  - It is independent of enp, ld and zera, so counters can cascade via ent, 74163 style.
  - Toggling up changes rco in the same cycle.
- wrap is high for exactly one clock cycle after each wrap edge. During continuous counting at M-1 -> 0 it pulses once per M cycles.
- Simultaneous events:
  - ld=0 with ent=enp=1: the load wins and no wrap pulse is produced.
  - zera=1 with ld=0: the clear wins.
- Direction change takes effect on the next counting edge. Q does not change when only up changes.
- Reset mid-operation: assertion of clr at any point within a cycle clears Q and wrap without waiting for a clock edge.

Test Plan:
- N=4, M=10. Pulse clr=0 mid-cycle, then hold ent=enp=1, up=1, ld=1, zera=0 for 12 edges.
  -> Q=0 asynchronously; Q then runs 1..9,0,1,2.
  -> rco=1 only while Q=9; wrap=1 only in the cycle after 9->0.
- N=4, M=10, up=0, starting from Q=0 with count enabled for 3 edges.
  -> Q=9,8,7; rco=1 only while Q=0; wrap=1 for one cycle after 0->9.
- N=4, M=10, load D=4'd13 with ld=0, then count up 1 edge; load D=13 again, then count down 2 edges.
  -> Up: Q=13 then Q=0 with wrap=1.
  -> Down: Q=13,12,11 with wrap=0 throughout.
- N=4, M=10, Q=9, up=1, ent=1, enp=0 for 3 edges.
  -> Q stays 9; rco=1; wrap=0.
  -> Then ent=0: rco=0 in the same cycle.
- N=4, M=10, Q=5. Cycle A: zera=1 and ld=0 with D=7. Cycle B: ld=0 with ent=enp=1.
  -> After A: Q=0.
  -> After B: Q=7, no increment, wrap=0.
- N=3, M=8, up=1, free-running 16 edges.
  -> Q wraps 7->0 twice; wrap pulses exactly twice, 8 cycles apart.
  -> clr asserted between edges forces Q=0 immediately.
